// File: rtl/hr_4t16_demux_align_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : hr_demux_pkg
//  Purpose  : Shared types and geometry for the 4:16 RX deserializer/aligner.
//  Revision : 1.0 - initial release
// ============================================================================
package hr_demux_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } demux_state_t;

    localparam int LANES  = 4;
    localparam int BEATS  = 4;
    localparam int WORD_W = 16;

endpackage
`default_nettype wire

// File: rtl/hr_4t16_deint.sv
`default_nettype none
// ============================================================================
//  Module   : hr_4t16_deint
//  Purpose  : Four-beat lane window, fill tracking and candidate-word mapping.
//  Revision : 1.0 - initial release
// ============================================================================
module hr_4t16_deint
    import hr_demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LANES-1:0]  din,
    output logic [WORD_W-1:0] cw,
    output logic              full
);

    // win_q[0] holds the oldest beat, win_q[BEATS-1] the newest
    logic [BEATS-1:0][LANES-1:0] win_q, win_d;
    logic [1:0]                  fill_q, fill_d;
    logic                        full_q, full_d;

    always_comb begin
        win_d  = {din, win_q[BEATS-1:1]};
        fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        // The saturated 2-bit count only reaches 3 after three beats; the
        // fourth captured beat is recorded by full_q.
        full_d = full_q | (fill_q == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q  <= '0;
            fill_q <= 2'd0;
            full_q <= 1'b0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
            full_q <= full_d;
        end
    end

    always_comb begin
        cw = '0;
        for (int b = 0; b < BEATS; b++) begin
            for (int k = 0; k < LANES; k++) begin
                cw[BEATS*k + b] = win_q[b][k];
            end
        end
    end

    assign full = full_q;

endmodule
`default_nettype wire

// File: rtl/hr_4t16_demux_align.sv
`default_nettype none
// ============================================================================
//  Module   : hr_4t16_demux_align
//  Purpose  : RX 4:16 deserializer with ALIGN_PAT word-boundary hunt and lock.
//             Define HR_DEMUX_LOSS_CNT_EN to add the lock_fail_cnt output.
//  Revision : 1.0 - initial release
// ============================================================================
module hr_4t16_demux_align
    import hr_demux_pkg::*;
#(
    parameter logic [WORD_W-1:0] ALIGN_PAT = 16'h5A3C,
    parameter int unsigned       LOCK_CNT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LANES-1:0]  din,
    input  logic              realign,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    output logic              locked,
    output logic [1:0]        state
`ifdef HR_DEMUX_LOSS_CNT_EN
    ,
    output logic [7:0]        lock_fail_cnt
`endif
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    logic [WORD_W-1:0] cw;
    logic              full;

    hr_4t16_deint u_deint (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .cw    (cw),
        .full  (full)
    );

    demux_state_t      state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [3:0]        match_cnt_q, match_cnt_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              w_match, w_boundary, w_check_fail;

    assign w_match      = full && (cw == ALIGN_PAT);
    assign w_boundary   = (phase_q == 2'd3);
    // realign takes priority, so a coincident mismatch is not a failure exit
    assign w_check_fail = (state_q == CHECK) && w_boundary && !w_match && !realign;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q + 2'd1;
        match_cnt_d  = match_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;

        if (realign) begin
            state_d = SEARCH;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (w_match) begin
                        phase_d     = 2'd0;
                        match_cnt_d = 4'd0;
                        state_d     = CHECK;
                    end
                end
                CHECK: begin
                    if (w_check_fail) begin
                        state_d = SEARCH;
                    end else if (w_boundary) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_q + 4'd1 == LOCK_TGT) begin
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (w_boundary) begin
                        dout_d       = cw;
                        dout_valid_d = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SEARCH;
            phase_q      <= 2'd0;
            match_cnt_q  <= 4'd0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            match_cnt_q  <= match_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign locked     = (state_q == LOCKED);
    assign state      = state_q;

`ifdef HR_DEMUX_LOSS_CNT_EN
    logic [7:0] lock_fail_cnt_q, lock_fail_cnt_d;

    always_comb begin
        lock_fail_cnt_d = lock_fail_cnt_q;
        if (w_check_fail && (lock_fail_cnt_q != 8'hFF)) begin
            lock_fail_cnt_d = lock_fail_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_fail_cnt_q <= 8'd0;
        end else begin
            lock_fail_cnt_q <= lock_fail_cnt_d;
        end
    end

    assign lock_fail_cnt = lock_fail_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hr_4t16_demux_align.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hr_4t16_demux_align
//  Purpose  : Randomized self-checking bench for hr_4t16_demux_align.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hr_4t16_demux_align;

    localparam logic [15:0] PAT    = 16'h5A3C;
    localparam int          LOCK_N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  din = 4'd0;
    logic        realign = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        locked;
    logic [1:0]  state;
`ifdef HR_DEMUX_LOSS_CNT_EN
    logic [7:0]  lock_fail_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hr_4t16_demux_align #(
        .ALIGN_PAT (PAT),
        .LOCK_CNT  (LOCK_N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .realign    (realign),
        .dout       (dout),
        .dout_valid (dout_valid),
        .locked     (locked),
        .state      (state)
`ifdef HR_DEMUX_LOSS_CNT_EN
        ,
        .lock_fail_cnt (lock_fail_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Reference model: the last four beats since reset, and word boundaries
    // measured as whole words from the edge where the hunt last hit.
    logic [3:0]  hist[$];
    int          m_state  = 0;
    int          m_t      = 0;
    int          m_anchor = 0;
    int          m_good   = 0;
    int          m_fails  = 0;
    logic [15:0] m_dout   = 16'h0;
    logic        m_valid  = 1'b0;

    function automatic logic [15:0] model_word();
        logic [15:0] w;
        logic [3:0]  beat;
        w = 16'h0;
        for (int b = 0; b < 4; b++) begin
            beat = hist[b];
            for (int k = 0; k < 4; k++) w[4*k + b] = beat[k];
        end
        return w;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] d, input logic ra);
        logic [15:0] w;
        logic        hit, bnd;
        m_t++;
        if (!r) begin
            hist.delete();
            m_state = 0; m_dout = 16'h0; m_valid = 1'b0; m_good = 0; m_fails = 0;
            return;
        end
        w       = (hist.size() == 4) ? model_word() : 16'h0;
        hit     = (hist.size() == 4) && (w == PAT);
        bnd     = ((m_t - m_anchor) % 4) == 0;
        m_valid = 1'b0;
        if (ra) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (hit) begin m_state = 1; m_anchor = m_t; m_good = 0; end
        end else if (m_state == 1) begin
            if (bnd) begin
                if (hit) begin
                    m_good++;
                    if (m_good == LOCK_N) m_state = 2;
                end else begin
                    m_state = 0;
                    if (m_fails < 255) m_fails++;
                end
            end
        end else if (bnd) begin
            m_dout  = w;
            m_valid = 1'b1;
        end
        hist.push_back(d);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic step(input logic r, input logic [3:0] d, input logic ra);
        rst_n = r; din = d; realign = ra;
        @(posedge clk);
        model_edge(r, d, ra);
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("locked", 32'(locked), 32'(m_state == 2));
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        chk("dout", 32'(dout), 32'(m_dout));
`ifdef HR_DEMUX_LOSS_CNT_EN
        chk("lock_fail_cnt", 32'(lock_fail_cnt), 32'(m_fails));
`endif
        @(negedge clk);
        realign = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int b = 0; b < 4; b++) step(1'b1, {w[12+b], w[8+b], w[4+b], w[b]}, 1'b0);
    endtask

    task automatic junk(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 4'($urandom), 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom), 1'b0);
    endtask

    initial begin
        int strobes;
        int reps;
        @(negedge clk);

        do_reset(3);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_state", 32'(state), 32'h0);

        // lock with the word boundary two beats in
        junk(2);
        for (int i = 0; i < 5; i++) send_word(PAT);
        chk("prelock_locked", 32'(locked), 32'h0);
        send_word(16'h1234);
        chk("lock_after_5", 32'(locked), 32'h1);
        junk(1);
        chk("first_word", 32'(dout), 32'h1234);
        chk("first_valid", 32'(dout_valid), 32'h1);
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            junk(1);
            if (dout_valid) strobes++;
        end
        chk("strobe_period", 32'(strobes), 32'd2);

        // CHECK failure
        do_reset(2);
        send_word(PAT);
        send_word(PAT);
        send_word(16'hFFFF);
        chk("pre_fail_state", 32'(state), 32'd1);
        junk(1);
        chk("fail_state", 32'(state), 32'd0);
        chk("fail_locked", 32'(locked), 32'h0);
`ifdef HR_DEMUX_LOSS_CNT_EN
        chk("fail_cnt_one", 32'(lock_fail_cnt), 32'd1);
`endif

        // realign on a boundary cycle while locked
        for (int i = 0; i < 5; i++) send_word(PAT);
        junk(6);
        chk("pre_realign_locked", 32'(locked), 32'h1);
        while (((m_t + 1 - m_anchor) % 4) != 0) junk(1);
        step(1'b1, 4'($urandom), 1'b1);
        chk("realign_valid", 32'(dout_valid), 32'h0);
        chk("realign_state", 32'(state), 32'd0);
        for (int i = 0; i < 5; i++) send_word(PAT);
        junk(1);
        chk("relock", 32'(locked), 32'h1);

        // reset while in CHECK; a pattern straddling reset must not match
        send_word(16'h0F0F);
        do_reset(1);
        send_word(PAT);
        junk(1);
        chk("mid_check_state", 32'(state), 32'd1);
        step(1'b0, 4'hA, 1'b0);
        step(1'b0, 4'h6, 1'b0);
        chk("midrst_dout", 32'(dout), 32'h0);
        chk("midrst_state", 32'(state), 32'd0);
        step(1'b1, 4'h9, 1'b0);
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'h0, 1'b0);
        step(1'b1, 4'h0, 1'b0);
        chk("no_false_match", 32'(state), 32'd0);

        // randomized mix of pattern bursts, data, odd shifts and realigns
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 4))
                0: begin
                    reps = $urandom_range(4, 7);
                    for (int i = 0; i < reps; i++) send_word(PAT);
                end
                1: send_word(16'($urandom));
                2: junk($urandom_range(1, 3));
                3: for (int i = 0; i < 3; i++) send_word(16'($urandom));
                default: step(1'b1, 4'($urandom), ($urandom_range(0, 3) == 0));
            endcase
        end

`ifdef HR_DEMUX_LOSS_CNT_EN
        for (int i = 0; i < 300; i++) begin
            send_word(PAT);
            send_word(16'hFFFF);
        end
        junk(1);
        chk("fail_cnt_sat", 32'(lock_fail_cnt), 32'hFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
